// File: rtl/adder_share_arbiter.sv
// Round-robin front end for a single shared W-bit adder: NREQ valid/ready requesters,
// one registered response slot carrying {carry, sum} and the owning requester ID.
module adder_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W:0]        rsp_sum,
    output logic [15:0]       grant_cnt
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    if (IDW != $clog2(NREQ)) begin : g_bad_idw
        $error("IDW must equal clog2(NREQ)");
    end

    slot_state_t          state_r;
    slot_state_t          state_nxt_s;
    logic [IDW-1:0]       ptr_r;
    logic [IDW-1:0]       ptr_nxt_s;
    logic [IDW-1:0]       grant_s;
    logic [IDW:0]         idx_wide_s;
    logic [IDW-1:0]       idx_s;
    logic                 found_s;
    logic                 can_accept_s;
    logic                 accept_s;
    logic [W-1:0]         op_a_s;
    logic [W-1:0]         op_b_s;
    logic [W:0]           sum_s;
    logic [NREQ-1:0]      req_ready_s;
    logic [IDW-1:0]       rsp_id_r;
    logic [W:0]           rsp_sum_r;
    logic [15:0]          grant_cnt_r;

    // Round-robin scan starting at ptr; the index wraps at NREQ, not at 2**IDW.
    always_comb begin
        found_s    = 1'b0;
        grant_s    = {IDW{1'b0}};
        idx_wide_s = {(IDW+1){1'b0}};
        idx_s      = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            idx_wide_s = {1'b0, ptr_r} + (IDW+1)'(k);
            idx_wide_s = (idx_wide_s >= (IDW+1)'(NREQ)) ? (idx_wide_s - (IDW+1)'(NREQ)) : idx_wide_s;
            idx_s      = idx_wide_s[IDW-1:0];
            grant_s    = (!found_s && req_valid[idx_s]) ? idx_s : grant_s;
            found_s    = found_s | req_valid[idx_s];
        end
    end

    // Operand mux, adder and one-hot ready for the granted lane.
    always_comb begin
        op_a_s      = {W{1'b0}};
        op_b_s      = {W{1'b0}};
        req_ready_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            op_a_s         = (grant_s == IDW'(i)) ? req_a[i*W +: W] : op_a_s;
            op_b_s         = (grant_s == IDW'(i)) ? req_b[i*W +: W] : op_b_s;
            req_ready_s[i] = accept_s && (grant_s == IDW'(i));
        end
        sum_s = {1'b0, op_a_s} + {1'b0, op_b_s};
    end

    // rsp_ready passes straight through so a full slot can drain and refill in one cycle.
    assign can_accept_s = (state_r == SLOT_EMPTY) || rsp_ready;
    assign accept_s     = rst_n && found_s && can_accept_s;
    assign ptr_nxt_s    = (grant_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (grant_s + IDW'(1));

    // Slot FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SLOT_EMPTY: state_nxt_s = accept_s ? SLOT_FULL : SLOT_EMPTY;
            SLOT_FULL:  state_nxt_s = (rsp_ready && !accept_s) ? SLOT_EMPTY : SLOT_FULL;
            default:    state_nxt_s = SLOT_EMPTY;
        endcase
    end

    // Slot FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= SLOT_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Response slot, priority pointer and transfer counter update only on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r       <= {IDW{1'b0}};
            rsp_id_r    <= {IDW{1'b0}};
            rsp_sum_r   <= {(W+1){1'b0}};
            grant_cnt_r <= 16'h0000;
        end else if (accept_s) begin
            ptr_r       <= ptr_nxt_s;
            rsp_id_r    <= grant_s;
            rsp_sum_r   <= sum_s;
            grant_cnt_r <= grant_cnt_r + 16'h0001;
        end else begin
            ptr_r       <= ptr_r;
            rsp_id_r    <= rsp_id_r;
            rsp_sum_r   <= rsp_sum_r;
            grant_cnt_r <= grant_cnt_r;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = (state_r == SLOT_FULL);
    assign rsp_id    = rsp_id_r;
    assign rsp_sum   = rsp_sum_r;
    assign grant_cnt = grant_cnt_r;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: a reference model predicts grants and results,
// a separate monitor compares the response slot and counter every cycle.
module tb_adder_share_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W:0]        rsp_sum;
    logic [15:0]       grant_cnt;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    logic [IDW+W:0]  sb[$];
    int              mptr = 0;
    int              mcnt = 0;
    logic [NREQ-1:0] seen_ready = '0;

    always #5 clk = ~clk;

    adder_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .grant_cnt(grant_cnt)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // First valid requester scanning p, p+1, ... modulo NREQ; -1 when none.
    function automatic int pick(logic [NREQ-1:0] v, int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference model: decides each cycle's accept and queues the expected response.
    initial begin : model
        logic [NREQ-1:0] exp_rdy;
        logic [IDW-1:0]  gid;
        logic [W:0]      s9;
        int              g;
        int              total;
        forever begin
            @(negedge clk);
            #1;
            if (armed) begin
                exp_rdy = '0;
                if (!rst_n) begin
                    sb.delete();
                    mptr = 0;
                    mcnt = 0;
                end else begin
                    g = pick(req_valid, mptr);
                    if (g >= 0 && (sb.size() == 0 || rsp_ready)) begin
                        exp_rdy[g] = 1'b1;
                        total = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
                        gid   = IDW'(g);
                        s9    = (W+1)'(total);
                        sb.push_back({gid, s9});
                        mptr = (g + 1) % NREQ;
                        mcnt++;
                    end
                end
                chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                seen_ready = req_ready;
            end
        end
    end

    // Monitor: compares the response slot against the queue head, pops on consumer handshake.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("rsp_valid", 32'(rsp_valid), 32'(sb.size() != 0));
                if (sb.size() != 0 && rsp_valid === 1'b1) begin
                    chk("rsp_id", 32'(rsp_id), 32'(sb[0][IDW+W:W+1]));
                    chk("rsp_sum", 32'(rsp_sum), 32'(sb[0][W:0]));
                end
                chk("grant_cnt", 32'(grant_cnt), 32'(mcnt & 32'hFFFF));
                if (sb.size() != 0 && rsp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_req(int i, bit v, logic [W-1:0] a, logic [W-1:0] b);
        req_valid[i]     = v;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin : stim
        logic [NREQ-1:0] rr_exp [6];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        tick();
        tick();
        settle();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        chk("rst_sum", 32'(rsp_sum), 32'h0);
        chk("rst_cnt", 32'(grant_cnt), 32'h0);
        req_valid = '0;
        rst_n     = 1'b1;
        armed     = 1'b1;

        // Single request from requester 2.
        tick();
        set_req(2, 1'b1, 8'h12, 8'h34);
        settle();
        chk("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        settle();
        chk("single_valid", 32'(rsp_valid), 32'h1);
        chk("single_id", 32'(rsp_id), 32'h2);
        chk("single_sum", 32'(rsp_sum), 32'h046);
        chk("single_cnt", 32'(grant_cnt), 32'h1);

        // Round robin with every requester held valid.
        tick();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(16 * i + 1), 8'(i + 3));
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            settle();
            chk("rr_ready", 32'(req_ready), 32'(rr_exp[k]));
            if (k > 0) chk("rr_valid", 32'(rsp_valid), 32'h1);
        end
        tick();
        req_valid = '0;

        // Backpressure and simultaneous drain+refill.
        tick();
        set_req(1, 1'b1, 8'hFF, 8'hFF);
        rsp_ready = 1'b0;
        settle();
        chk("bp_accept", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        set_req(3, 1'b1, 8'h05, 8'h07);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            settle();
            chk("bp_sum", 32'(rsp_sum), 32'h1FE);
            chk("bp_id", 32'(rsp_id), 32'h1);
            chk("bp_stall_ready", 32'(req_ready), 32'h0);
        end
        tick();
        rsp_ready = 1'b1;
        settle();
        chk("bp_refill", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        settle();
        chk("bp_new_id", 32'(rsp_id), 32'h3);
        chk("bp_new_sum", 32'(rsp_sum), 32'h00C);

        // Priority after a skipped range: ptr=1 with only 0 and 3 valid.
        tick();
        do_reset();
        set_req(0, 1'b1, 8'h01, 8'h02);
        settle();
        chk("skip_first", 32'(req_ready), 32'b0001);
        tick();
        set_req(0, 1'b1, 8'h03, 8'h04);
        set_req(3, 1'b1, 8'h05, 8'h06);
        settle();
        chk("skip_to3", 32'(req_ready), 32'b1000);
        tick();
        req_valid[3] = 1'b0;
        settle();
        chk("skip_to0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;

        // Reset with a pending response and ptr=2.
        tick();
        do_reset();
        set_req(1, 1'b1, 8'h10, 8'h20);
        rsp_ready = 1'b0;
        settle();
        chk("mid_accept", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        settle();
        chk("mid_pending", 32'(rsp_valid), 32'h1);
        do_reset();
        set_req(0, 1'b1, 8'h21, 8'h22);
        set_req(2, 1'b1, 8'h23, 8'h24);
        rsp_ready = 1'b1;
        settle();
        chk("mid_valid", 32'(rsp_valid), 32'h0);
        chk("mid_cnt", 32'(grant_cnt), 32'h0);
        chk("mid_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid[0] = 1'b0;
        tick();
        req_valid = '0;

        // Randomised traffic with held requests and random backpressure.
        for (int n = 0; n < 1500; n++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !seen_ready[i])) begin
                    if ($urandom_range(0, 2) != 0) begin
                        set_req(i, 1'b1,
                                ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom),
                                ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom));
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();

        // Counter wrap after 65536 accepts.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(i * 40 + 7), 8'hF0);
        repeat (65536) tick();
        req_valid = '0;
        settle();
        chk("wrap_cnt", 32'(grant_cnt), 32'h0);
        chk("wrap_valid", 32'(rsp_valid), 32'h1);
        tick();
        tick();

        armed = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
